// File: rtl/mc_fifo_pkg.sv
// Shared constants and width helpers for the multi-channel FIFO.
//   DefDataW/DefDepth/DefNumCh : default parameter values
//   StatCntW                   : width of the optional error-event counters
//   ch_w()/addr_w()            : channel-select and per-channel address widths
package mc_fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefNumCh = 4;
  localparam int unsigned StatCntW = 16;

  // Smallest w with 2**w >= n.
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // A single channel still needs a one-bit select field.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : log2_ceil(num_ch);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return log2_ceil(depth);
  endfunction

endpackage

// File: rtl/mc_fifo_if.sv
// Write/read request bus of the multi-channel FIFO.
//   master : drives wr_en/wr_ch/wr_data and rd_en/rd_ch, receives rd_data/rd_valid
//   slave  : the FIFO side of the same signals
interface mc_fifo_if #(
  parameter int unsigned DATA_W = mc_fifo_pkg::DefDataW,
  parameter int unsigned NUM_CH = mc_fifo_pkg::DefNumCh
);
  import mc_fifo_pkg::*;

  localparam int unsigned CH_W = ch_w(NUM_CH);

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/mc_fifo_mem.sv
// Simple dual-port storage for all channels: one write port, one synchronous read port.
//   clk_i, rst_ni          : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i          : read request; rdata_o updates the cycle after re_i, else holds
module mc_fifo_mem
  import mc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ENTRIES = DefNumCh * DefDepth,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // The array is deliberately not reset; only the output register is.
  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel FIFO: NUM_CH independent FIFOs of DEPTH words sharing one RAM.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : write request (wr_en/wr_ch/wr_data), read request (rd_en/rd_ch),
//                       read return (rd_data/rd_valid, one cycle after an accepted read)
//   full/empty/almost_full : per-channel status, registered
//   count             : per-channel occupancy, channel i at [i*(AW+1) +: AW+1]
//   err_ovf/err_udf   : one-cycle pulse after a write to full / read from empty channel
//   ovf_cnt/udf_cnt   : saturating error-event counters, only with MC_FIFO_STATS_EN
module mc_fifo
  import mc_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned AF_LVL = DEPTH - 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  mc_fifo_if.slave                             bus,
  output logic [NUM_CH-1:0]                    full,
  output logic [NUM_CH-1:0]                    empty,
  output logic [NUM_CH-1:0]                    almost_full,
  output logic [NUM_CH*(addr_w(DEPTH)+1)-1:0]  count,
  output logic                                 err_ovf,
  output logic                                 err_udf
`ifdef MC_FIFO_STATS_EN
  ,
  output logic [StatCntW-1:0]                  ovf_cnt,
  output logic [StatCntW-1:0]                  udf_cnt
`endif
);

  localparam int unsigned CH_W  = ch_w(NUM_CH);
  localparam int unsigned AW    = addr_w(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned MemAw = CH_W + AW;

  logic [CH_W-1:0]   wr_ch, rd_ch;
  logic [PW-1:0]     wr_ptr_q [NUM_CH];
  logic [PW-1:0]     wr_ptr_d [NUM_CH];
  logic [PW-1:0]     rd_ptr_q [NUM_CH];
  logic [PW-1:0]     rd_ptr_d [NUM_CH];
  logic [PW-1:0]     cnt_q    [NUM_CH];
  logic [PW-1:0]     cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic              wr_acc, rd_acc, err_ovf_d, err_udf_d;
  logic              rd_valid_q, err_ovf_q, err_udf_q;

  // With a single channel the select field is ignored so it can never index past the arrays.
  assign wr_ch = (NUM_CH > 1) ? bus.wr_ch : '0;
  assign rd_ch = (NUM_CH > 1) ? bus.rd_ch : '0;

  // Acceptance uses pre-edge status, so full+rd+wr reads only and empty+rd+wr writes only.
  assign wr_acc    = bus.wr_en & ~full_q[wr_ch];
  assign rd_acc    = bus.rd_en & ~empty_q[rd_ch];
  assign err_ovf_d = bus.wr_en & full_q[wr_ch];
  assign err_udf_d = bus.rd_en & empty_q[rd_ch];

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
    end
    if (wr_acc) wr_ptr_d[wr_ch] = wr_ptr_q[wr_ch] + PW'(1);
    if (rd_acc) rd_ptr_d[rd_ch] = rd_ptr_q[rd_ch] + PW'(1);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i]   = wr_ptr_d[i] - rd_ptr_d[i];
      empty_d[i] = (wr_ptr_d[i] == rd_ptr_d[i]);
      full_d[i]  = (wr_ptr_d[i][AW-1:0] == rd_ptr_d[i][AW-1:0]) &&
                   (wr_ptr_d[i][AW] != rd_ptr_d[i][AW]);
      af_d[i]    = (cnt_d[i] >= PW'(AF_LVL));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      full_q     <= '0;
      empty_q    <= '1;
      af_q       <= '0;
      rd_valid_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      rd_valid_q <= rd_acc;
      err_ovf_q  <= err_ovf_d;
      err_udf_q  <= err_udf_d;
    end
  end

  mc_fifo_mem #(
    .DATA_W  (DATA_W),
    .ENTRIES (NUM_CH * DEPTH),
    .ADDR_W  (MemAw)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wr_acc),
    .waddr_i ({wr_ch, wr_ptr_q[wr_ch][AW-1:0]}),
    .wdata_i (bus.wr_data),
    .re_i    (rd_acc),
    .raddr_i ({rd_ch, rd_ptr_q[rd_ch][AW-1:0]}),
    .rdata_o (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign err_ovf      = err_ovf_q;
  assign err_udf      = err_udf_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count
    assign count[g*PW +: PW] = cnt_q[g];
  end

`ifdef MC_FIFO_STATS_EN
  logic [StatCntW-1:0] ovf_cnt_q, udf_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      if (err_ovf_d && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + StatCntW'(1);
      if (err_udf_d && (udf_cnt_q != '1)) udf_cnt_q <= udf_cnt_q + StatCntW'(1);
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo at default parameters: per-channel queue model,
// per-cycle comparison of every output, plus hand-computed literal expectations.
module tb_mc_fifo;
  import mc_fifo_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned DP  = 16;
  localparam int unsigned NC  = 4;
  localparam int unsigned PW  = 5;
  localparam int unsigned AFL = DP - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mc_fifo_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();

  logic [NC-1:0]    full, empty, af;
  logic [NC*PW-1:0] count;
  logic             err_ovf, err_udf;
`ifdef MC_FIFO_STATS_EN
  logic [15:0]      ovf_cnt, udf_cnt;
`endif

  mc_fifo #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .NUM_CH (NC),
    .AF_LVL (AFL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .full        (full),
    .empty       (empty),
    .almost_full (af),
    .count       (count),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
`ifdef MC_FIFO_STATS_EN
    ,
    .ovf_cnt     (ovf_cnt),
    .udf_cnt     (udf_cnt)
`endif
  );

  // Behavioural model: one queue per channel plus the expected registered outputs.
  logic [DW-1:0] mq [NC][$];
  logic          exp_rd_valid;
  logic [DW-1:0] exp_rd_data;
  logic          exp_ovf, exp_udf;
  int            exp_ovf_cnt, exp_udf_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NC-1:0]    e_full, e_empty, e_af;
      logic [NC*PW-1:0] e_cnt;
      for (int c = 0; c < NC; c++) begin
        e_full[c]         = (mq[c].size() == DP);
        e_empty[c]        = (mq[c].size() == 0);
        e_af[c]           = (mq[c].size() >= AFL);
        e_cnt[c*PW +: PW] = PW'(mq[c].size());
      end
      chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rd_valid));
      chk("rd_data", 32'(bus.rd_data), 32'(exp_rd_data));
      chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
      chk("err_udf", 32'(err_udf), 32'(exp_udf));
      chk("full", 32'(full), 32'(e_full));
      chk("empty", 32'(empty), 32'(e_empty));
      chk("almost_full", 32'(af), 32'(e_af));
      chk("count", 32'(count), 32'(e_cnt));
`ifdef MC_FIFO_STATS_EN
      chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf_cnt));
      chk("udf_cnt", 32'(udf_cnt), 32'(exp_udf_cnt));
`endif
    end
  end

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    exp_rd_valid = 1'b0;
    exp_rd_data  = '0;
    exp_ovf      = 1'b0;
    exp_udf      = 1'b0;
    exp_ovf_cnt  = 0;
    exp_udf_cnt  = 0;
  endtask

  // Drive one request set and advance the model by the rules of the FIFO.
  task automatic drive(input bit we, input int wc, input logic [DW-1:0] wd,
                       input bit re, input int rc);
    bit wa, ra;
    bus.wr_en   = we;
    bus.wr_ch   = 2'(wc);
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.rd_ch   = 2'(rc);
    wa = we && (mq[wc].size() < DP);
    ra = re && (mq[rc].size() > 0);
    exp_ovf      = we && !wa;
    exp_udf      = re && !ra;
    exp_rd_valid = ra;
    if (ra) exp_rd_data = mq[rc].pop_front();
    if (wa) mq[wc].push_back(wd);
    if (exp_ovf && exp_ovf_cnt < 65535) exp_ovf_cnt++;
    if (exp_udf && exp_udf_cnt < 65535) exp_udf_cnt++;
  endtask

  task automatic cycle(input bit we, input int wc, input logic [DW-1:0] wd,
                       input bit re, input int rc);
    drive(we, wc, wd, re, rc);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 0, '0, 1'b0, 0);
  endtask

  task automatic apply_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_ch   = '0;
    #1;
    chk_en = 1'b1;
    apply_reset();

    // Reset state
    chk("rst empty", 32'(empty), 32'hF);
    chk("rst full", 32'(full), 32'h0);
    chk("rst count", 32'(count), 32'h0);
    chk("rst rd_valid", 32'(bus.rd_valid), 32'h0);

    // Three words through channel 2
    cycle(1, 2, 8'h11, 0, 0);
    cycle(1, 2, 8'h22, 0, 0);
    cycle(1, 2, 8'h33, 0, 0);
    cycle(0, 0, 8'h00, 1, 2);
    chk("ch2 rd0", 32'(bus.rd_data), 32'h11);
    cycle(0, 0, 8'h00, 1, 2);
    chk("ch2 rd1", 32'(bus.rd_data), 32'h22);
    cycle(0, 0, 8'h00, 1, 2);
    chk("ch2 rd2", 32'(bus.rd_data), 32'h33);
    chk("ch2 valid", 32'(bus.rd_valid), 32'h1);
    chk("ch2 empty", 32'(empty[2]), 32'h1);
    idle();
    chk("ch2 valid drop", 32'(bus.rd_valid), 32'h0);
    chk("ch2 data hold", 32'(bus.rd_data), 32'h33);

    // Fill channel 0, overflow, read back
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 8'(i * 7 + 1), 0, 0);
      if (i == 12) chk("af at 13", 32'(af[0]), 32'h0);
      if (i == 13) chk("af at 14", 32'(af[0]), 32'h1);
    end
    chk("ch0 full", 32'(full[0]), 32'h1);
    chk("ch0 count16", 32'(count[0 +: PW]), 32'd16);
    cycle(1, 0, 8'hFF, 0, 0);
    chk("ovf pulse", 32'(err_ovf), 32'h1);
    idle();
    chk("ovf single", 32'(err_ovf), 32'h0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("ch0 first", 32'(bus.rd_data), 32'h01);
    for (int i = 1; i < 16; i++) cycle(0, 0, 8'h00, 1, 0);
    chk("ch0 last", 32'(bus.rd_data), 32'h6A);
    chk("ch0 empty", 32'(empty[0]), 32'h1);

    // Read empty channel 3 while writing it
    cycle(1, 3, 8'hA5, 1, 3);
    chk("udf pulse", 32'(err_udf), 32'h1);
    chk("udf no valid", 32'(bus.rd_valid), 32'h0);
    chk("ch3 count1", 32'(count[3*PW +: PW]), 32'd1);
    cycle(0, 0, 8'h00, 1, 3);
    chk("ch3 data", 32'(bus.rd_data), 32'hA5);

    // Channel 1 full, simultaneous write and read
    for (int i = 0; i < 16; i++) cycle(1, 1, 8'(8'h40 + i), 0, 0);
    cycle(1, 1, 8'hEE, 1, 1);
    chk("ch1 oldest", 32'(bus.rd_data), 32'h40);
    chk("ch1 ovf", 32'(err_ovf), 32'h1);
    chk("ch1 count15", 32'(count[PW +: PW]), 32'd15);
    for (int i = 0; i < 15; i++) cycle(0, 0, 8'h00, 1, 1);
    chk("ch1 tail", 32'(bus.rd_data), 32'h4F);

    // Interleaved ch0/ch1 traffic, 40 words each (pointers wrap)
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 8'($urandom), 1, 1);
      cycle(1, 1, 8'($urandom), 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 8'h00, 1, 0);
      cycle(0, 0, 8'h00, 1, 1);
    end

    // Random traffic over all channels
    for (int i = 0; i < 2000; i++) begin
      bit we, re;
      we = ($urandom_range(0, 99) < ((i % 400) < 200 ? 75 : 35));
      re = ($urandom_range(0, 99) < ((i % 400) < 200 ? 35 : 75));
      cycle(we, int'($urandom_range(0, NC - 1)), 8'($urandom),
            re, int'($urandom_range(0, NC - 1)));
    end

    // Reset while ch0 holds words and a read is in flight
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hC0 + i), 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.rd_en = 1'b0;
    model_reset();
    #1;
    chk("arst rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("arst empty0", 32'(empty[0]), 32'h1);
    chk("arst count0", 32'(count[0 +: PW]), 32'd0);
`ifdef MC_FIFO_STATS_EN
    chk("arst ovf_cnt", 32'(ovf_cnt), 32'h0);
    chk("arst udf_cnt", 32'(udf_cnt), 32'h0);
`endif
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1, 0, 8'h5A, 0, 0);
    cycle(0, 0, 8'h00, 1, 0);
    chk("post-rst data", 32'(bus.rd_data), 32'h5A);
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
